// File: rtl/conv_pixel_feeder_if.sv
// Pixel stream bundle between the capture path (master) and the pixel feeder (slave).
// valid/ready: there is no ready; every pix_valid cycle is either accepted or dropped, and read qualifies data_out/x/y.
interface conv_pixel_feeder_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] pix_in;
  logic              pix_valid;
  logic              frame_start;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              read;
  logic [10:0]       x;
  logic [10:0]       y;
  logic              frame_done;
  logic              err;
  logic              busy;
  logic [1:0]        fsm_state;

  modport master (
    output pix_in, pix_valid, frame_start, err_clr,
    input  data_out, read, x, y, frame_done, err, busy, fsm_state
  );

  modport slave (
    input  pix_in, pix_valid, frame_start, err_clr,
    output data_out, read, x, y, frame_done, err, busy, fsm_state
  );
endinterface

// File: rtl/conv_pixel_feeder.sv
// Tags incoming gray pixels with {read, y, x, data} for the 3x3 convolution and,
// after the last pixel of a frame, issues read=0 bubbles to drain the line buffers.
module conv_pixel_feeder #(
  parameter int IMG_W     = 1280,
  parameter int IMG_H     = 960,
  parameter int DATA_W    = 12,
  parameter int FLUSH_CYC = IMG_W + 3
) (
  input logic                clk,
  input logic                rst_n,
  conv_pixel_feeder_if.slave bus
);
  localparam int FC_W = $clog2(FLUSH_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  localparam logic [10:0]     X_LAST  = 11'(IMG_W - 1);
  localparam logic [10:0]     Y_LAST  = 11'(IMG_H - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYC);

  logic [1:0]        state;
  logic [10:0]       xcnt;
  logic [10:0]       ycnt;
  logic [FC_W-1:0]   fcnt;
  logic [DATA_W-1:0] data_q;
  logic              read_q;
  logic [10:0]       x_q;
  logic [10:0]       y_q;
  logic              done_q;
  logic              err_q;

  logic        accept;
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic        last_px;
  logic        err_set;

  // frame_start restarts the raster, so a coincident pixel is always (0,0)
  assign accept  = bus.pix_valid && (bus.frame_start || (state == S_ACTIVE));
  assign cur_x   = bus.frame_start ? 11'd0 : xcnt;
  assign cur_y   = bus.frame_start ? 11'd0 : ycnt;
  assign last_px = (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign err_set = (bus.pix_valid && !accept) || (bus.frame_start && (state == S_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      xcnt   <= '0;
      ycnt   <= '0;
      fcnt   <= '0;
      data_q <= '0;
      read_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_set | (err_q & ~bus.err_clr);
      if (accept) begin
        data_q <= bus.pix_in;
        read_q <= 1'b1;
        x_q    <= cur_x;
        y_q    <= cur_y;
        if (last_px) begin
          state <= S_FLUSH;
          fcnt  <= '0;
          xcnt  <= '0;
          ycnt  <= '0;
        end else begin
          state <= S_ACTIVE;
          if (cur_x == X_LAST) begin
            xcnt <= '0;
            ycnt <= cur_y + 11'd1;
          end else begin
            xcnt <= cur_x + 11'd1;
            ycnt <= cur_y;
          end
        end
      end else begin
        read_q <= 1'b0;
        if (bus.frame_start) begin
          state <= S_ACTIVE;
          xcnt  <= '0;
          ycnt  <= '0;
        end else if (state == S_FLUSH) begin
          // FLUSH_CYC bubble cycles, then one more cycle to raise frame_done
          if (fcnt == FC_LAST) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            data_q <= '0;
            fcnt   <= fcnt + FC_W'(1);
          end
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.read       = read_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.frame_done = done_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.fsm_state  = state;
endmodule
